// File: rtl/mem_port_adapter.sv
// CPU-to-memory port adapter: captures one CPU request, presents it to the
// memory port with lane-shifted mask/data, waits for completion or timeout,
// and returns a single-cycle response to the CPU.
//
// state | meaning
// IDLE  | no transaction; accept a new CPU request
// WAIT  | strobe asserted toward memory; counting cycles until pmem_resp or timeout
// DONE  | one-cycle mem_resp pulse to the CPU, strobes low
module mem_port_adapter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [3:0]  pmem_byte_enable,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal count: abort after TIMEOUT cycles spent in WAIT.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [3:0]  be_shift;
  logic [31:0] wdata_shift;

  // Move the CPU byte mask and store data onto the lanes selected by the
  // low address bits; bits shifted past the word are dropped.
  assign be_shift    = 4'(mem_byte_enable << mem_address[1:0]);
  assign wdata_shift = 32'(mem_wdata << {mem_address[1:0], 3'b000});

  // Transaction FSM; every output is a register so memory sees stable,
  // glitch-free strobes and the CPU inputs are irrelevant after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      mem_rdata        <= 32'd0;
      mem_resp         <= 1'b0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= 32'd0;
      pmem_byte_enable <= 4'd0;
      pmem_wdata       <= 32'd0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_resp <= 1'b0;
          if (mem_read || mem_write) begin
            pmem_address     <= {mem_address[31:2], 2'b00};
            pmem_byte_enable <= be_shift;
            pmem_wdata       <= wdata_shift;
            // A simultaneous read and write is served as a read.
            pmem_read        <= mem_read;
            pmem_write       <= ~mem_read;
            wait_cnt         <= 8'd0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          // Completion takes priority over a timeout in the same cycle.
          if (pmem_resp) begin
            if (pmem_read) mem_rdata <= pmem_rdata;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            state      <= DONE;
          end else if (wait_cnt == LAST_CNT) begin
            if (pmem_read) mem_rdata <= 32'd0;
            timeout_err <= 1'b1;
            pmem_read   <= 1'b0;
            pmem_write  <= 1'b0;
            mem_resp    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          mem_resp <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_resp   <= 1'b0;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_adapter.sv
// Directed bench for mem_port_adapter with a response scoreboard: each
// transaction pushes its expected CPU response, and a monitor pops and checks
// whenever mem_resp is seen.
module tb_mem_port_adapter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = 4'd0;
  logic [31:0] mem_address = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata = 32'd0;
  logic        pmem_resp = 1'b0;
  logic        timeout_err;

  mem_port_adapter #(.TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata = 32'd0;
  logic        model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every mem_resp pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_mem_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        chk("sb_mem_rdata", mem_rdata, e.rdata);
        chk("sb_timeout_err", {31'd0, timeout_err}, {31'd0, e.err});
      end
    end
  end

  // One CPU transaction. d = cycles from first strobe to pmem_resp (0 = same
  // cycle as first strobe), d < 0 means memory never answers.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input int d,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    resp_t e;
    int    lat;
    int    nwait;
    int    exp_lat;
    logic  is_rd;
    is_rd = rd;
    lat   = 0;
    nwait = 0;
    exp_lat = (d < 0) ? TMO + 1 : d + 2;
    if (d < 0) begin
      model_err = 1'b1;
      if (is_rd) model_rdata = 32'd0;
    end else if (is_rd) begin
      model_rdata = rdata;
    end
    e.rdata = model_rdata;
    e.err   = model_err;
    sb_q.push_back(e);

    @(posedge clk); #1;
    chk("idle_no_resp", {31'd0, mem_resp}, 32'd0);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wdata;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        mem_address     = ~addr;
        mem_byte_enable = ~be;
        mem_wdata       = 32'h5555_AAAA;
      end
      if (mem_resp === 1'b1) begin
        lat = cyc;
        break;
      end
      nwait++;
      chk("wait_pmem_read", {31'd0, pmem_read}, {31'd0, is_rd});
      chk("wait_pmem_write", {31'd0, pmem_write}, {31'd0, ~is_rd});
      chk("wait_pmem_address", pmem_address, exp_addr);
      chk("wait_pmem_be", {28'd0, pmem_byte_enable}, {28'd0, exp_be});
      chk("wait_pmem_wdata", pmem_wdata, exp_wdata);
      if (d >= 0 && cyc == d + 1) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = 32'hBAD0_0000 | 32'(cyc);
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    chk("resp_latency", 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk("wait_cycles", 32'(nwait), 32'(exp_lat - 1));
      chk("done_strobes_low", {30'd0, pmem_read, pmem_write}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_strobes", {30'd0, pmem_read, pmem_write}, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    chk("rst_pmem_be", {28'd0, pmem_byte_enable}, 32'd0);
    chk("rst_pmem_wdata", pmem_wdata, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    // Stray memory response while idle must be ignored.
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("idle_pmem_resp_ignored", {31'd0, mem_resp}, 32'd0);
    chk("idle_rdata_unchanged", mem_rdata, 32'd0);

    // Read, responds 3 cycles after strobe (lands on the timeout cycle: resp wins).
    do_txn(1, 0, 32'h0000_1006, 4'b0011, 32'h1122_3344, 3, 32'hDEAD_BEEF,
           32'h0000_1004, 4'b1100, 32'h3344_0000);
    // Write at byte 3.
    do_txn(0, 1, 32'h0000_2003, 4'b0001, 32'h0000_00A5, 2, 32'h0,
           32'h0000_2000, 4'b1000, 32'hA500_0000);
    // Write with mask and data truncated past the word.
    do_txn(0, 1, 32'h0000_0043, 4'b1111, 32'hAABB_CCDD, 1, 32'h0,
           32'h0000_0040, 4'b1000, 32'hDD00_0000);
    // Read and write together: read wins.
    do_txn(1, 1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 1, 32'hCAFE_F00D,
           32'h0000_0010, 4'b1111, 32'h1234_5678);
    // Minimum latency, back-to-back.
    do_txn(1, 0, 32'h0000_0020, 4'b1111, 32'h0, 0, 32'h0123_4567,
           32'h0000_0020, 4'b1111, 32'h0);
    do_txn(1, 0, 32'h0000_0025, 4'b0001, 32'h0000_00FF, 0, 32'h89AB_CDEF,
           32'h0000_0024, 4'b0010, 32'h0000_FF00);
    // Timeout on a read, then a good write keeps the sticky error.
    do_txn(1, 0, 32'h0000_0030, 4'b1111, 32'h0, -1, 32'h0,
           32'h0000_0030, 4'b1111, 32'h0);
    do_txn(0, 1, 32'h0000_0040, 4'b0011, 32'h0000_BEEF, 1, 32'h0,
           32'h0000_0040, 4'b0011, 32'h0000_BEEF);
    chk("err_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset two cycles into WAIT aborts without a response.
    @(posedge clk); #1;
    mem_read        = 1'b1;
    mem_address     = 32'h0000_0060;
    mem_byte_enable = 4'b1111;
    @(posedge clk); #1;
    chk("abort_strobe_on", {31'd0, pmem_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_strobes_low", {30'd0, pmem_read, pmem_write}, 32'd0);
    chk("abort_no_resp", {31'd0, mem_resp}, 32'd0);
    chk("abort_err_cleared", {31'd0, timeout_err}, 32'd0);
    mem_read = 1'b0;
    rst      = 1'b0;
    model_err   = 1'b0;
    model_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", {29'd0, mem_resp, pmem_read, pmem_write}, 32'd0);
    end
    do_txn(1, 0, 32'h0000_0050, 4'b1111, 32'h0, 2, 32'h5A5A_1234,
           32'h0000_0050, 4'b1111, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_adapter.md
MEM_PORT_ADAPTER -- requirements
Module: mem_port_adapter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max WAIT cycles before abort; legal range 1..255.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_read  in  1  CPU read request, held high until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held high until mem_resp.
REQ-006 mem_byte_enable  in  4  CPU byte mask, relative to mem_address[1:0].
REQ-007 mem_address  in  32  CPU byte address.
REQ-008 mem_wdata  in  32  CPU store data, LSB-justified.
REQ-009 mem_rdata  out  32  registered read data, aligned word.
REQ-010 mem_resp  out  1  one-cycle completion pulse to CPU control.
REQ-011 pmem_read  out  1  memory read strobe.
REQ-012 pmem_write  out  1  memory write strobe.
REQ-013 pmem_address  out  32  word-aligned memory address.
REQ-014 pmem_byte_enable  out  4  lane-shifted byte mask.
REQ-015 pmem_wdata  out  32  lane-shifted store data.
REQ-016 pmem_rdata  in  32  memory read data, valid with pmem_resp.
REQ-017 pmem_resp  in  1  memory completion.
REQ-018 timeout_err  out  1  sticky flag: a transaction timed out.

Function
REQ-019 FSM states IDLE, WAIT, DONE; IDLE after reset.
REQ-020 IDLE: on mem_read|mem_write, capture request into registers and go to WAIT next cycle; otherwise stay.
REQ-021 Both mem_read and mem_write high in IDLE: read served, write ignored for that transaction.
REQ-022 Captured address = {mem_address[31:2],2'b00}; sh = mem_address[1:0].
REQ-023 Captured mask = (mem_byte_enable << sh) truncated to 4 bits; captured data = (mem_wdata << 8*sh) truncated to 32 bits.
REQ-024 pmem_* outputs driven only from captured registers; CPU input changes after capture have no effect.
REQ-025 WAIT: exactly one of pmem_read/pmem_write high every cycle; address/mask/data stable throughout.
REQ-026 WAIT: 8-bit cycle counter cleared on entry, +1 per WAIT cycle.
REQ-027 WAIT with pmem_resp=1: reads load mem_rdata <= pmem_rdata; go to DONE.
REQ-028 WAIT, pmem_resp=0 and counter == TIMEOUT-1: set timeout_err, load mem_rdata <= 0 for reads, go to DONE.
REQ-029 pmem_resp and timeout in same cycle: pmem_resp wins, no error.
REQ-030 DONE: mem_resp=1 for exactly one cycle, pmem strobes low; go to IDLE unconditionally.
REQ-031 Latency: request seen cycle 0 -> strobe cycle 1 -> pmem_resp cycle k (k>=1) -> mem_resp cycle k+1; minimum 2 cycles.
REQ-032 Back-to-back: request high in IDLE immediately after DONE starts a new transaction; no idle gap beyond the IDLE cycle.
REQ-033 pmem_resp in IDLE or DONE ignored.
REQ-034 mem_rdata holds its value until the next read completion; writes do not change it.
REQ-035 timeout_err cleared only by rst.

Reset
REQ-036 rst=1: state IDLE; counter 0; mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_byte_enable, pmem_wdata, timeout_err all 0 the cycle after.
REQ-037 rst mid-WAIT aborts transaction: strobes low next cycle, no mem_resp issued.

Verification
REQ-038 Read, addr 0x0000_1006, be 4'b0011, pmem_resp 3 cycles after strobe with rdata 0xDEAD_BEEF -> pmem_address 0x0000_1004, pmem_byte_enable 4'b1100, mem_resp one cycle, mem_rdata 0xDEAD_BEEF.
REQ-039 Write, addr 0x0000_2003, be 4'b0001, wdata 0x0000_00A5 -> pmem_byte_enable 4'b1000, pmem_wdata 0xA500_0000, pmem_write held until pmem_resp.
REQ-040 TIMEOUT=4, read, pmem_resp never -> 4 WAIT cycles, timeout_err=1, mem_resp pulse, mem_rdata 0x0000_0000; err remains after next good transaction.
REQ-041 mem_read and mem_write both high, addr 0x10 -> pmem_read=1, pmem_write=0 throughout.
REQ-042 rst asserted 2 cycles into WAIT -> strobes 0 next cycle, mem_resp never pulses; new read afterwards completes normally.
REQ-043 pmem_resp in same cycle as first strobe, then immediate second request -> mem_resp pulses 2 cycles after each request, both data values correct.
